// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hub75_pkg
// Description : Shared constants for the HUB75 row capture block: default
//               geometry, RGB bit indices and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hub75_pkg;

  localparam int COLS_DEFAULT   = 64;
  localparam int ADDR_W_DEFAULT = 4;
  localparam int RGB_W          = 6;

  // Bit positions inside the {R0,G0,B0,R1,G1,B1} pixel word
  localparam int R0 = 5;
  localparam int G0 = 4;
  localparam int B0 = 3;
  localparam int R1 = 2;
  localparam int G1 = 1;
  localparam int B1 = 0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_COMMIT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/hub75_in_cond.sv
`default_nettype none
// ============================================================================
// Module      : hub75_in_cond
// Description : Input conditioning for one panel signal: optional 2-flop
//               synchronizer (HUB75_ROW_CAPTURE_SYNC_EN) and rising-edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_in_cond #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [W-1:0] r_prev;

`ifdef HUB75_ROW_CAPTURE_SYNC_EN
  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;
`else
  assign q = d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= '0;
    else     r_prev <= q;
  end

  assign rise = q & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/hub75_row_capture.sv
`default_nettype none
// ============================================================================
// Module      : hub75_row_capture
// Description : Captures one HUB75 row from the panel shift bus into a
//               double buffer; commits on latch when exactly COLS were shifted.
//               Define HUB75_ROW_CAPTURE_SYNC_EN to synchronize all panel inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_row_capture
  import hub75_pkg::*;
#(
  parameter int COLS   = COLS_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hub_sclk,
  input  logic                    hub_lat,
  input  logic                    hub_oe,
  input  logic [ADDR_W-1:0]       hub_addr,
  input  logic [RGB_W-1:0]        hub_rgb,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic [RGB_W-1:0]        rd_data,
  output logic                    row_valid,
  output logic [ADDR_W-1:0]       row_addr,
  output logic [$clog2(COLS):0]   col_count,
  output logic                    err_len,
  output logic                    err_oe,
  output logic                    busy
);

  localparam int              CW     = $clog2(COLS);
  localparam int              NW     = CW + 1;
  localparam logic [NW-1:0]   C_COLS = NW'(COLS);
  localparam logic [NW-1:0]   C_SAT  = NW'(COLS + 1);

  logic                w_sclk_rise, w_lat_rise, w_oe;
  logic [ADDR_W-1:0]   w_addr;
  logic [RGB_W-1:0]    w_rgb;
  logic                w_unused_sclk_lvl, w_unused_lat_lvl, w_unused_oe_rise;
  logic [ADDR_W-1:0]   w_unused_addr_rise;
  logic [RGB_W-1:0]    w_unused_rgb_rise;

  hub75_in_cond #(.W(1)) u_cond_sclk (
    .clk(clk), .rst(rst), .d(hub_sclk), .q(w_unused_sclk_lvl), .rise(w_sclk_rise));
  hub75_in_cond #(.W(1)) u_cond_lat (
    .clk(clk), .rst(rst), .d(hub_lat), .q(w_unused_lat_lvl), .rise(w_lat_rise));
  hub75_in_cond #(.W(1)) u_cond_oe (
    .clk(clk), .rst(rst), .d(hub_oe), .q(w_oe), .rise(w_unused_oe_rise));
  hub75_in_cond #(.W(ADDR_W)) u_cond_addr (
    .clk(clk), .rst(rst), .d(hub_addr), .q(w_addr), .rise(w_unused_addr_rise));
  hub75_in_cond #(.W(RGB_W)) u_cond_rgb (
    .clk(clk), .rst(rst), .d(hub_rgb), .q(w_rgb), .rise(w_unused_rgb_rise));

  state_t              r_state, w_state_nxt;
  logic [NW-1:0]       r_col_count, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_lat_addr;
  logic [RGB_W-1:0]    r_shift [COLS];
  logic [RGB_W-1:0]    r_disp  [COLS];
  logic                w_wr_en, w_commit, w_len_err;
  logic [CW-1:0]       w_wr_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A shift edge coinciding with a latch in IDLE still goes through COMMIT
  // so the pixel is counted before the length check.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_sclk_rise && w_lat_rise) w_state_nxt = ST_COMMIT;
        else if (w_sclk_rise)          w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT:  if (w_lat_rise) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = w_sclk_rise ? ST_SHIFT : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = '0;
    w_cnt_nxt = r_col_count;
    w_commit  = 1'b0;
    w_len_err = 1'b0;
    case (r_state)
      ST_COMMIT: begin
        w_commit  = (r_col_count == C_COLS);
        w_len_err = (r_col_count != C_COLS);
        w_cnt_nxt = '0;
        if (w_sclk_rise) begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = NW'(1);
        end
      end
      default: begin
        if (w_sclk_rise) begin
          if (r_col_count < C_COLS) begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_col_count[CW-1:0];
          end
          if (r_col_count != C_SAT) w_cnt_nxt = r_col_count + NW'(1);
        end
        if ((r_state == ST_IDLE) && w_lat_rise && !w_sclk_rise) w_len_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_count <= '0;
      r_lat_addr  <= '0;
      row_addr    <= '0;
      row_valid   <= 1'b0;
      err_len     <= 1'b0;
      err_oe      <= 1'b0;
      for (int i = 0; i < COLS; i++) begin
        r_shift[i] <= '0;
        r_disp[i]  <= '0;
      end
    end else begin
      r_col_count <= w_cnt_nxt;
      row_valid   <= w_commit;
      err_len     <= w_len_err;
      err_oe      <= w_sclk_rise & ~w_oe;
      if (w_lat_rise) r_lat_addr <= w_addr;
      if (w_wr_en)    r_shift[w_wr_idx] <= w_rgb;
      if (w_commit) begin
        r_disp   <= r_shift;
        row_addr <= r_lat_addr;
      end
    end
  end

  // Reads see the display buffer before any commit on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        rd_data <= '0;
    else if ({1'b0, rd_col} < C_COLS) rd_data <= r_disp[rd_col];
    else                            rd_data <= '0;
  end

  assign col_count = r_col_count;
  assign busy      = (r_state == ST_SHIFT) || (r_state == ST_COMMIT);

endmodule
`default_nettype wire
